mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one mux4 datapath between four requesters.
- Grants one requester at a time and drives the mux4 select from the grant.
- Presents the winner's data word on a single output.
- Sits between the CPU-side masters and any shared WIDTH-bit resource; the existing mux4 is instantiated as the datapath.

---
 rtl/mux4_arbiter_pkg.sv | 18 +
 rtl/mux4_arbiter_if.sv | 28 ++
 rtl/mux4.sv | 24 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/mux4_arbiter.sv | 132 +++++++++++++
 tb/tb_mux4_arbiter.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the mux4 round-robin arbiter.
package mux4_arbiter_pkg;

  // Width of the select / pointer / winner index.
  localparam int unsigned SelW = 2;

  // Arbiter states: ArbIdle = 1'b0, ArbGrant = 1'b1.
  typedef enum logic {
    ArbIdle  = 1'b0,
    ArbGrant = 1'b1
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [3:0] onehot4(input logic [SelW-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_arbiter_if.sv
// Request/data/grant bundle between the four requesters and the arbiter.
interface mux4_arbiter_if #(
  parameter int unsigned WIDTH = 4
);

  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [WIDTH-1:0] y;

  // Requester side.
  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, sel, busy, y
  );

  // Arbiter side.
  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, sel, busy, y
  );

endinterface

// File: rtl/mux4.sv
// Four-input WIDTH-bit multiplexer used as the shared datapath.
module mux4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Select one of the four words.
  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning ptr+1, ptr+2, ... mod 4.
module rr_pick4
  import mux4_arbiter_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [SelW-1:0] ptr,
  output logic            found,
  output logic [SelW-1:0] win
);

  logic [SelW-1:0] idx;

  // Scan from furthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + SelW'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter sharing one mux4 between four requesters.
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input logic          clock,
  input logic          reset_n,
  mux4_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  arb_state_e      state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [3:0]      pick_mask;
  logic            found;
  logic [SelW-1:0] win;
  logic            owner_req;
  logic            take_new;
  logic            go_idle;
  logic            busy;
  logic [WIDTH-1:0] mux_y;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       hold_expired;
  assign hold_expired = (hold_q >= HoldLast);
`endif

  // Owner is masked out so a preemption never re-picks it; when the owner
  // has dropped its request the mask is a no-op.
  assign pick_mask = bus.req & ~gnt_q;
  assign owner_req = |(bus.req & gnt_q);

  rr_pick4 u_pick (
    .req   (pick_mask),
    .ptr   (ptr_q),
    .found (found),
    .win   (win)
  );

  // Next-state: pick in idle, hand off without a bubble, optional preemption.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    take_new = 1'b0;
    go_idle  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d   = hold_q;
`endif

    unique case (state_q)
      ArbIdle: take_new = found;
      ArbGrant: begin
        if (owner_req) begin
`ifdef ARB_TIMEOUT_EN
          take_new = hold_expired && found;
          if (!hold_expired) hold_d = hold_q + 8'd1;
`else
          take_new = 1'b0;
`endif
        end else begin
          take_new = found;
          go_idle  = !found;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (take_new) begin
      state_d = ArbGrant;
      gnt_d   = onehot4(win);
      sel_d   = win;
      ptr_d   = win;
`ifdef ARB_TIMEOUT_EN
      hold_d  = 8'd0;
`endif
    end else if (go_idle) begin
      state_d = ArbIdle;
      gnt_d   = 4'b0000;
    end
  end

  // State registers; ptr resets to 3 so requester 0 has first priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ArbIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= '0;
      ptr_q   <= SelW'(3);
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  mux4 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign busy     = |gnt_q;
  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy;
  assign bus.y    = mux_y & {WIDTH{busy}};

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter; expected outputs go through a scoreboard queue.
module tb_mux4_arbiter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] y;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  logic [WIDTH-1:0] dv[4];

  mux4_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux4_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic obs_t expect_for(input logic [3:0] g);
    obs_t e;
    e.gnt  = g;
    e.sel  = 2'd0;
    e.busy = |g;
    e.y    = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        e.sel = 2'(i);
        e.y   = dv[i];
      end
    end
    return e;
  endfunction

  // sel is only meaningful while busy.
  function automatic obs_t observe(input logic exp_busy);
    obs_t o;
    o.gnt  = bus.gnt;
    o.sel  = exp_busy ? bus.sel : 2'd0;
    o.busy = bus.busy;
    o.y    = bus.y;
    return o;
  endfunction

  task automatic drive(input logic [3:0] r, input logic [3:0] g);
    bus.req = r;
    sb.push_back(expect_for(g));
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus.req = 4'b0000;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] rq[2] = '{4'b1111, 4'b0000};
    logic [3:0] eg[2] = '{4'b0001, 4'b0000};
    obs_t exp, obs;
    reset_n = 1'b0;
    bus.req = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(expect_for(4'b0000));
    exp = sb.pop_front();
    obs = observe(exp.busy);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b busy=%b y=%h, want gnt=%b busy=%b y=%h",
               obs.gnt, obs.busy, obs.y, exp.gnt, exp.busy, exp.y);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(rq[i], eg[i]);
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_release step %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 i, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  task automatic test_single_owner();
    obs_t exp, obs;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        drive(4'b0100, 4'b0100);
      end else if (i == 5) begin
        // Data change must show on y in the same cycle.
        dv[2]  = 4'hA;
        bus.d2 = 4'hA;
        #1;
        sb.push_back(expect_for(4'b0100));
      end else begin
        dv[2]  = 4'h5;
        bus.d2 = 4'h5;
        drive(4'b0000, 4'b0000);
      end
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_owner step %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 i, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rq[9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                          4'b1111, 4'b1011, 4'b1111, 4'b0111};
    logic [3:0] eg[9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                          4'b0100, 4'b1000, 4'b1000, 4'b0001};
    obs_t exp, obs;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(rq[i], eg[i]);
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL round_robin step %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 i, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rq[6] = '{4'b0011, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] eg[6] = '{4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
    obs_t exp, obs;
    for (int i = 0; i < 6; i++) begin
      drive(rq[i], eg[i]);
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back step %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 i, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t exp, obs;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        drive(4'b0010, 4'b0010);
      end else if (i == 2) begin
        #2;
        reset_n = 1'b0;
        #1;
        sb.push_back(expect_for(4'b0000));
      end else begin
        #1;
        reset_n = 1'b1;
        drive(4'b1111, 4'b0001);
      end
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL async_reset step %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 i, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t exp, obs;
    logic [3:0] eg;
    apply_reset();
    for (int k = 1; k <= 37; k++) begin
      if (k <= 16) begin
`ifdef ARB_TIMEOUT_EN
        eg = ((((k - 1) / MAX_HOLD) % 2) != 0) ? 4'b0010 : 4'b0001;
`else
        eg = 4'b0001;
`endif
        drive(4'b0011, eg);
      end else if (k <= 36) begin
        drive(4'b0001, 4'b0001);
      end else begin
        drive(4'b0000, 4'b0000);
      end
      exp = sb.pop_front();
      obs = observe(exp.busy);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout edge %0d: got gnt=%b sel=%0d busy=%b y=%h, want gnt=%b sel=%0d busy=%b y=%h",
                 k, obs.gnt, obs.sel, obs.busy, obs.y, exp.gnt, exp.sel, exp.busy, exp.y);
      end
    end
  endtask

  initial begin
    dv[0] = 4'h0;
    dv[1] = 4'h1;
    dv[2] = 4'h5;
    dv[3] = 4'hF;
    bus.d0  = dv[0];
    bus.d1  = dv[1];
    bus.d2  = dv[2];
    bus.d3  = dv[3];
    bus.req = 4'b0000;
    reset_n = 1'b0;

    test_reset();
    test_single_owner();
    test_round_robin();
    test_back_to_back();
    test_async_reset();
    test_timeout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
